// File: rtl/jogador_automatico.sv
// Auto-player for the memory game: pulses iniciar, plays a scripted one-hot
// sequence on chaves (optionally one wrong play) and checks how the game ended.
//
// state   | meaning
// IDLE    | waiting for comecar, all outputs low
// INICIA  | holding iniciar high
// PRE     | chaves=0 gap before the first play
// APERTA  | driving play k on chaves
// SOLTA   | chaves=0 gap after a play
// AGUARDA | waiting for pronto, bounded by T_LIMITE
// FIM     | result valid on sucesso/timeout
module jogador_automatico #(
  parameter int N_JOGADAS = 16,
  parameter int T_INICIAR = 5,
  parameter int T_PRESS   = 10,
  parameter int T_GAP     = 10,
  parameter int T_LIMITE  = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       comecar,
  input  logic       modo_erro,
  input  logic [3:0] jogada_erro,
  input  logic       pronto,
  input  logic       acertou,
  input  logic       errou,
  output logic       iniciar,
  output logic [3:0] chaves,
  output logic       ocupado,
  output logic       fim,
  output logic       sucesso,
  output logic       timeout,
  output logic [3:0] db_estado,
  output logic [3:0] db_jogada
);

  localparam int T_MAX_A = (T_INICIAR > T_PRESS) ? T_INICIAR : T_PRESS;
  localparam int T_MAX_B = (T_GAP > T_LIMITE) ? T_GAP : T_LIMITE;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int CW      = ($clog2(T_MAX) > 0) ? $clog2(T_MAX) : 1;

  typedef enum logic [3:0] {
    S_IDLE    = 4'h0,
    S_INICIA  = 4'h1,
    S_PRE     = 4'h2,
    S_APERTA  = 4'h3,
    S_SOLTA   = 4'h4,
    S_AGUARDA = 4'h5,
    S_FIM     = 4'hF
  } estado_t;

  estado_t       estado, estado_prox;
  logic [CW-1:0] cnt, cnt_prox;
  logic [3:0]    k, k_prox;
  logic          armado_q, armado_prox;
  logic [3:0]    jog_erro_q, jog_erro_prox;
  logic          sucesso_prox, timeout_prox;
  logic          pronto_r, acertou_r, errou_r;

  logic          jogada_errada, ultima, resultado_ok, erro_na_prox;
  logic [1:0]    idx_prox;
  logic [3:0]    chaves_prox;

  assign jogada_errada = armado_q && (k == jog_erro_q);
  assign ultima        = (k == 4'(N_JOGADAS - 1));
  assign resultado_ok  = armado_q ? (errou_r && !acertou_r) : (acertou_r && !errou_r);

  // chaves is registered from the next state so the game never sees a decode glitch
  assign erro_na_prox = armado_q && (k_prox == jog_erro_q);
  assign idx_prox     = k_prox[1:0] + {1'b0, erro_na_prox};
  assign chaves_prox  = (estado_prox == S_APERTA) ? (4'b0001 << idx_prox) : 4'b0000;

  always_comb begin
    estado_prox   = estado;
    k_prox        = k;
    cnt_prox      = (cnt != '0) ? cnt - CW'(1) : cnt;
    armado_prox   = armado_q;
    jog_erro_prox = jog_erro_q;
    sucesso_prox  = sucesso;
    timeout_prox  = timeout;

    unique case (estado)
      S_IDLE, S_FIM: begin
        if (comecar) begin
          estado_prox   = S_INICIA;
          cnt_prox      = CW'(T_INICIAR - 1);
          k_prox        = '0;
          armado_prox   = modo_erro && ({1'b0, jogada_erro} < 5'(N_JOGADAS));
          jog_erro_prox = jogada_erro;
          sucesso_prox  = 1'b0;
          timeout_prox  = 1'b0;
        end
      end
      S_INICIA: begin
        if (cnt == '0) begin
          estado_prox = S_PRE;
          cnt_prox    = CW'(T_GAP - 1);
        end
      end
      S_PRE: begin
        if (cnt == '0) begin
          estado_prox = S_APERTA;
          cnt_prox    = CW'(T_PRESS - 1);
        end
      end
      S_APERTA: begin
        if (cnt == '0) begin
          estado_prox = S_SOLTA;
          cnt_prox    = CW'(T_GAP - 1);
        end
      end
      S_SOLTA: begin
        if (cnt == '0) begin
          if (jogada_errada || ultima) begin
            estado_prox = S_AGUARDA;
            cnt_prox    = CW'(T_LIMITE - 1);
          end else begin
            estado_prox = S_APERTA;
            k_prox      = k + 4'd1;
            cnt_prox    = CW'(T_PRESS - 1);
          end
        end
      end
      S_AGUARDA: begin
        if (cnt == '0) begin
          estado_prox  = S_FIM;
          timeout_prox = 1'b1;
          sucesso_prox = 1'b0;
        end
      end
      default: estado_prox = S_IDLE;
    endcase

    // pronto before AGUARDA is a premature end and never counts as success
    if (pronto_r && (estado == S_PRE || estado == S_APERTA ||
                     estado == S_SOLTA || estado == S_AGUARDA)) begin
      estado_prox  = S_FIM;
      k_prox       = k;
      timeout_prox = 1'b0;
      sucesso_prox = (estado == S_AGUARDA) && resultado_ok;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= S_IDLE;
      cnt        <= '0;
      k          <= '0;
      armado_q   <= 1'b0;
      jog_erro_q <= '0;
      sucesso    <= 1'b0;
      timeout    <= 1'b0;
      iniciar    <= 1'b0;
      chaves     <= '0;
      pronto_r   <= 1'b0;
      acertou_r  <= 1'b0;
      errou_r    <= 1'b0;
    end else begin
      estado     <= estado_prox;
      cnt        <= cnt_prox;
      k          <= k_prox;
      armado_q   <= armado_prox;
      jog_erro_q <= jog_erro_prox;
      sucesso    <= sucesso_prox;
      timeout    <= timeout_prox;
      iniciar    <= (estado_prox == S_INICIA);
      chaves     <= chaves_prox;
      pronto_r   <= pronto;
      acertou_r  <= acertou;
      errou_r    <= errou;
    end
  end

  assign ocupado   = (estado != S_IDLE) && (estado != S_FIM);
  assign fim       = (estado == S_FIM);
  assign db_estado = estado;
  assign db_jogada = k;

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: behavioural game model drives the status
// inputs; a monitor checks plays and end results against queued expectations.
module tb_jogador_automatico;

  localparam int N  = 4;
  localparam int TI = 5;
  localparam int TP = 5;
  localparam int TG = 10;
  localparam int TL = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       comecar = 1'b0;
  logic       modo_erro = 1'b0;
  logic [3:0] jogada_erro = 4'd0;
  logic       pronto = 1'b0, acertou = 1'b0, errou = 1'b0;
  logic       iniciar, ocupado, fim, sucesso, timeout;
  logic [3:0] chaves, db_estado, db_jogada;

  jogador_automatico #(
    .N_JOGADAS(N), .T_INICIAR(TI), .T_PRESS(TP), .T_GAP(TG), .T_LIMITE(TL)
  ) dut (
    .clock(clock), .reset(reset), .comecar(comecar), .modo_erro(modo_erro),
    .jogada_erro(jogada_erro), .pronto(pronto), .acertou(acertou), .errou(errou),
    .iniciar(iniciar), .chaves(chaves), .ocupado(ocupado), .fim(fim),
    .sucesso(sucesso), .timeout(timeout), .db_estado(db_estado), .db_jogada(db_jogada)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       suc;
    logic       tmo;
    logic [3:0] jog;
    bit         chk_lat;
  } fim_t;

  logic [3:0] exp_plays[$];
  fim_t       exp_fins[$];
  int         checks = 0;
  int         failures = 0;

  logic [3:0] seq_ok[4]   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] seq_err3[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};

  task automatic verifica(string nome, logic [31:0] atual, logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
    end
  endtask

  // game model: 0 normal, 1 silent, 2 premature pronto, 3 reports acertou on a wrong play
  int         modelo_modo = 0;
  int         prem_idx = 0;
  int         g_idx = 0;
  int         g_wait = -1;
  logic [3:0] g_prev = 4'd0;
  bit         g_err = 1'b0, g_last = 1'b0;

  always @(negedge clock) begin
    if (reset || iniciar) begin
      pronto = 1'b0; acertou = 1'b0; errou = 1'b0;
      g_idx = 0; g_wait = -1; g_prev = 4'd0; g_err = 1'b0; g_last = 1'b0;
    end else begin
      if (chaves != 4'd0 && g_prev == 4'd0) begin
        g_err  = (chaves != (4'b0001 << (g_idx % 4)));
        g_last = (g_idx == N - 1);
        if (modelo_modo == 2 && g_idx == prem_idx) begin
          pronto = 1'b1; acertou = 1'b0; errou = 1'b0;
        end
      end
      if (chaves == 4'd0 && g_prev != 4'd0) begin
        if (g_err || g_last) g_wait = 12;
        g_idx++;
      end
      if (g_wait > 0) g_wait--;
      if (g_wait == 0) begin
        g_wait = -1;
        if (modelo_modo != 1) begin
          pronto = 1'b1;
          if (g_err && modelo_modo != 3) begin errou = 1'b1; acertou = 1'b0; end
          else begin acertou = 1'b1; errou = 1'b0; end
        end
      end
      g_prev = chaves;
    end
  end

  // monitor
  logic [3:0] m_prev = 4'd0;
  logic       fim_prev = 1'b0;
  int         press_len = 0, gap_len = 0, ini_len = 0, agu_len = 0;
  bit         gap_ativo = 1'b0;
  fim_t       m_e;

  always @(negedge clock) begin
    if (reset) begin
      m_prev = 4'd0; fim_prev = 1'b0; press_len = 0; gap_len = 0;
      ini_len = 0; agu_len = 0; gap_ativo = 1'b0;
    end else begin
      if (iniciar) begin
        ini_len++; gap_ativo = 1'b0; agu_len = 0;
      end else if (ini_len != 0) begin
        verifica("iniciar_len", ini_len, TI);
        ini_len = 0;
      end
      if (db_estado == 4'h5) agu_len++;
      if (chaves != 4'd0) begin
        if (m_prev == 4'd0) begin
          if (gap_ativo) verifica("gap_len", gap_len, TG);
          gap_ativo = 1'b0;
          if (exp_plays.size() == 0) begin
            checks++; failures++;
            $display("FAIL play_unexpected: got %b expected none", chaves);
          end else begin
            verifica("play_value", chaves, exp_plays.pop_front());
          end
          press_len = 1;
        end else begin
          press_len++;
        end
      end else begin
        if (m_prev != 4'd0) begin
          if (!fim) verifica("press_len", press_len, TP);
          gap_ativo = 1'b1; gap_len = 1;
        end else if (gap_ativo) begin
          gap_len++;
        end
      end
      if (fim && !fim_prev) begin
        gap_ativo = 1'b0;
        if (exp_fins.size() == 0) begin
          checks++; failures++;
          $display("FAIL end_unexpected: got fim=1 expected no end");
        end else begin
          m_e = exp_fins.pop_front();
          verifica("sucesso", sucesso, m_e.suc);
          verifica("timeout", timeout, m_e.tmo);
          verifica("db_jogada", db_jogada, m_e.jog);
          if (m_e.chk_lat) verifica("aguarda_len", agu_len, TL);
        end
        verifica("plays_pending", exp_plays.size(), 0);
      end
      m_prev = chaves; fim_prev = fim;
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic empurra(int sel, int n, logic s, logic t, logic [3:0] j, bit lat);
    fim_t e;
    for (int i = 0; i < n; i++) exp_plays.push_back(sel == 0 ? seq_ok[i] : seq_err3[i]);
    e.suc = s; e.tmo = t; e.jog = j; e.chk_lat = lat;
    exp_fins.push_back(e);
  endtask

  task automatic inicia(logic me, logic [3:0] je);
    modo_erro = me; jogada_erro = je;
    tick(); comecar = 1'b1;
    tick(); comecar = 1'b0;
  endtask

  task automatic espera_fim(int limite);
    int n = 0;
    while (!fim && n < limite) begin @(negedge clock); n++; end
    if (!fim) begin
      checks++; failures++;
      $display("FAIL wait_fim: fim=0 after %0d cycles, expected 1", limite);
    end
    tick(); tick();
  endtask

  task automatic espera_chaves(bit nao_zero, int limite);
    int n = 0;
    while (((chaves != 4'd0) != nao_zero) && n < limite) begin @(negedge clock); n++; end
    if ((chaves != 4'd0) != nao_zero) begin
      checks++; failures++;
      $display("FAIL wait_chaves: chaves=%b after %0d cycles", chaves, limite);
    end
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clock);
    verifica("rst_outputs", {iniciar, chaves, ocupado, fim, sucesso, timeout}, 9'd0);
    verifica("rst_db_estado", db_estado, 4'h0);
    verifica("rst_db_jogada", db_jogada, 4'h0);

    // all correct
    modelo_modo = 0;
    empurra(0, 4, 1'b1, 1'b0, 4'd3, 1'b0);
    inicia(1'b0, 4'd0);
    espera_fim(300);

    // wrong 4th play; config changed after start must not matter
    modelo_modo = 0;
    empurra(1, 4, 1'b1, 1'b0, 4'd3, 1'b0);
    inicia(1'b1, 4'd3);
    modo_erro = 1'b0; jogada_erro = 4'd0;
    espera_fim(300);

    // wrong play but game claims acertou
    modelo_modo = 3;
    empurra(1, 4, 1'b0, 1'b0, 4'd3, 1'b0);
    inicia(1'b1, 4'd3);
    espera_fim(300);

    // silent game
    modelo_modo = 1;
    empurra(0, 4, 1'b0, 1'b1, 4'd3, 1'b1);
    inicia(1'b0, 4'd0);
    espera_fim(300);

    // premature pronto during play index 1
    modelo_modo = 2; prem_idx = 1;
    empurra(0, 2, 1'b0, 1'b0, 4'd1, 1'b0);
    inicia(1'b0, 4'd0);
    espera_fim(300);

    // reset in the middle of the first play
    modelo_modo = 0;
    exp_plays.push_back(seq_ok[0]);
    inicia(1'b0, 4'd0);
    espera_chaves(1'b1, 100);
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge clock);
    verifica("rst_mid_chaves", chaves, 4'd0);
    verifica("rst_mid_ocupado", ocupado, 1'b0);
    verifica("rst_mid_db_estado", db_estado, 4'h0);
    verifica("rst_mid_iniciar", iniciar, 1'b0);
    empurra(0, 4, 1'b1, 1'b0, 4'd3, 1'b0);
    inicia(1'b0, 4'd0);
    espera_fim(300);

    // comecar while busy is ignored, comecar in FIM restarts
    modelo_modo = 0;
    empurra(0, 4, 1'b1, 1'b0, 4'd3, 1'b0);
    inicia(1'b0, 4'd0);
    espera_chaves(1'b1, 100);
    espera_chaves(1'b0, 100);
    tick(); comecar = 1'b1;
    tick(); comecar = 1'b0;
    espera_fim(300);
    empurra(0, 4, 1'b1, 1'b0, 4'd3, 1'b0);
    tick(); comecar = 1'b1;
    tick(); comecar = 1'b0;
    @(negedge clock);
    verifica("restart_sucesso", sucesso, 1'b0);
    verifica("restart_iniciar", iniciar, 1'b1);
    verifica("restart_fim", fim, 1'b0);
    espera_fim(300);

    repeat (3) tick();
    verifica("plays_left", exp_plays.size(), 0);
    verifica("ends_left", exp_fins.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
